// File: rtl/cdc_handshake_tx.sv
// Source end of a four-phase req/ack crossing: captures one word and holds it while req_out is high.
// Latency: req_out rises one edge after accept; done pulses SYNC_DEPTH+1 edges after ack_in falls.
// Backpressure: ready_out is high only in IDLE; valid_in while busy is dropped and sets sticky overflow.
module cdc_handshake_tx #(
   parameter int SYNC_DEPTH     = 2,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk_fast,
   input  logic                  rst_fast,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  req_out,
   input  logic                  ack_in,
   output logic                  done,
   output logic                  overflow,
   input  logic                  clr_err,
   output logic                  timeout_err
);

   // Counter is wide enough to hold TIMEOUT_CYCLES itself so it can saturate there.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

   state_t                  state_q;
   logic                    ready_q;
   logic                    req_q;
   logic                    done_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [SYNC_DEPTH-1:0]   sync_q;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;
   logic                    tmo_q, tmo_d;

   logic                    accept;
   logic                    ack_sync;
   logic                    phase_change;
   logic                    busy_hold;
   logic                    tmo_hit;

   assign ready_out   = ready_q;
   assign data_out    = data_q;
   assign req_out     = req_q;
   assign done        = done_q;
   assign overflow    = ovf_q;
   assign timeout_err = tmo_q;

   // Next-state for the phase counter and the two sticky flags (set beats clear).
   always_comb begin
      accept   = valid_in && ready_q;
      ack_sync = sync_q[SYNC_DEPTH-1];
      phase_change = 1'b0;
      case (state_q)
         IDLE:    phase_change = accept;
         REQ:     phase_change = ack_sync;
         REL:     phase_change = !ack_sync;
         default: phase_change = 1'b1;
      endcase
      busy_hold = (state_q != IDLE) && !phase_change;
      cnt_d = '0;
      if (busy_hold) begin
         cnt_d = (cnt_q != CNT_MAX) ? cnt_q + CNT_ONE : cnt_q;
      end
      // Fires only on the edge the count reaches the limit, so a later clear sticks.
      tmo_hit = (TIMEOUT_CYCLES > 0) && busy_hold && (cnt_q == CNT_LAST);
      ovf_d   = (ovf_q && !clr_err) || (valid_in && !ready_q);
      tmo_d   = (tmo_q && !clr_err) || tmo_hit;
   end

   // Bring the asynchronous ack into clk_fast through a plain flop chain.
   always_ff @(posedge clk_fast) begin
      if (rst_fast) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], ack_in};
      end
   end

   // Phase counter and sticky error flags.
   always_ff @(posedge clk_fast) begin
      if (rst_fast) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         tmo_q <= tmo_d;
      end
   end

   // Handshake FSM; all outputs registered so req_out cannot glitch.
   always_ff @(posedge clk_fast) begin
      if (rst_fast) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  data_q  <= data_in;
                  req_q   <= 1'b1;
                  ready_q <= 1'b0;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (ack_sync) begin
                  req_q   <= 1'b0;
                  state_q <= REL;
               end
            end
            REL: begin
               if (!ack_sync) begin
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               req_q   <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
